dmem_port_arbiter: RTL

Two-requester arbiter and access sequencer in front of the single-ported data memory. Port 0 is the pipeline MEM stage and port 1 is the debug/loader master. The block serialises their reads and writes onto one memory port, holds each command for exactly one access cycle, and returns read data with a valid strobe after a fixed memory latency. Port 0 has priority, and a starvation guard bounds how long port 1 can wait.

---
 rtl/dmem_port_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter and access sequencer for the single-ported data memory.
// Port 0 has priority; a starvation counter guarantees port 1 a slot.
module dmem_port_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned LAT_W    = 2;
  localparam int unsigned STARVE_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [STARVE_W-1:0] starve_cnt, starve_nx;
  logic [LAT_W-1:0]    lat_cnt, lat_nx;
  logic                cmd_we, cmd_we_nx;
  logic                cmd_port, cmd_port_nx;
  logic [ADDR_W-1:0]   mem_addr_nx;
  logic [DATA_W-1:0]   mem_wdata_nx;
  logic                p0_gnt_nx, p1_gnt_nx;
  logic                p0_rvalid_nx, p1_rvalid_nx;
  logic [DATA_W-1:0]   p0_rdata_nx, p1_rdata_nx;
  logic                mem_read_nx, mem_write_nx;
  logic                busy_nx;
  logic                win1;
  logic                capture;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      lat_cnt    <= '0;
      cmd_we     <= 1'b0;
      cmd_port   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      p0_gnt     <= 1'b0;
      p1_gnt     <= 1'b0;
      p0_rvalid  <= 1'b0;
      p1_rvalid  <= 1'b0;
      p0_rdata   <= '0;
      p1_rdata   <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      starve_cnt <= starve_nx;
      lat_cnt    <= lat_nx;
      cmd_we     <= cmd_we_nx;
      cmd_port   <= cmd_port_nx;
      mem_addr   <= mem_addr_nx;
      mem_wdata  <= mem_wdata_nx;
      p0_gnt     <= p0_gnt_nx;
      p1_gnt     <= p1_gnt_nx;
      p0_rvalid  <= p0_rvalid_nx;
      p1_rvalid  <= p1_rvalid_nx;
      p0_rdata   <= p0_rdata_nx;
      p1_rdata   <= p1_rdata_nx;
      mem_read   <= mem_read_nx;
      mem_write  <= mem_write_nx;
      busy       <= busy_nx;
    end
  end

  // Next state, arbitration and next output values
  always_comb begin
    state_nx     = state;
    starve_nx    = starve_cnt;
    lat_nx       = lat_cnt;
    cmd_we_nx    = cmd_we;
    cmd_port_nx  = cmd_port;
    mem_addr_nx  = mem_addr;
    mem_wdata_nx = mem_wdata;
    p0_gnt_nx    = 1'b0;
    p1_gnt_nx    = 1'b0;
    p0_rvalid_nx = 1'b0;
    p1_rvalid_nx = 1'b0;
    p0_rdata_nx  = p0_rdata;
    p1_rdata_nx  = p1_rdata;
    mem_read_nx  = 1'b0;
    mem_write_nx = 1'b0;
    win1         = 1'b0;
    capture      = 1'b0;

    unique case (state)
      IDLE: begin
        if (p0_req || p1_req) begin
          win1 = p1_req && (!p0_req || (starve_cnt == STARVE_W'(MAX_WAIT)));
          if (win1 || !p1_req) begin
            starve_nx = '0;
          end else if (starve_cnt < STARVE_W'(MAX_WAIT)) begin
            starve_nx = starve_cnt + STARVE_W'(1);
          end
          cmd_port_nx  = win1;
          cmd_we_nx    = win1 ? p1_we : p0_we;
          mem_addr_nx  = win1 ? p1_addr : p0_addr;
          mem_wdata_nx = win1 ? p1_wdata : p0_wdata;
          p0_gnt_nx    = !win1;
          p1_gnt_nx    = win1;
          mem_read_nx  = !cmd_we_nx;
          mem_write_nx = cmd_we_nx;
          state_nx     = ACCESS;
        end
      end
      ACCESS: begin
        if (cmd_we) begin
          state_nx = IDLE;
        end else if (MEM_LAT == 1) begin
          capture  = 1'b1;
          state_nx = IDLE;
        end else begin
          lat_nx   = LAT_W'(MEM_LAT - 1);
          state_nx = WAIT;
        end
      end
      WAIT: begin
        lat_nx = lat_cnt - LAT_W'(1);
        if (lat_cnt == LAT_W'(1)) begin
          capture  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Read data goes only to the port that owns the command
    if (capture) begin
      if (cmd_port) begin
        p1_rdata_nx  = mem_rdata;
        p1_rvalid_nx = 1'b1;
      end else begin
        p0_rdata_nx  = mem_rdata;
        p0_rvalid_nx = 1'b1;
      end
    end

    busy_nx = (state_nx != IDLE);
  end

endmodule
